uart_fifo_ctrl: RTL and testbench
=================================

# uart_fifo_ctrl

Memory-mapped UART controller that sits between the CPU data-memory bus and the UART TX/RX cores. It buffers CPU transmit bytes in a TX FIFO and sequences the TX core's TX_EN/TX_STATUS handshake. It captures received bytes into an RX FIFO on RX_STATUS strobes, and exposes control, status and a level interrupt in the 0x4000_0018–0x4000_0024 peripheral window.

## Interface
- DEPTH, 8: entries per FIFO; power of two, 2..8.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Addr  in  32  byte address from the ALU.
- WriteData  in  32  store data.
- MemRd  in  1  load strobe; one access per cycle.
- MemWr  in  1  store strobe; one access per cycle.
- ReadData  out  32  combinational load data; 0 when MemRd=0 or address unmapped.
- UART_TXD  out  8  byte presented to the TX core.
- TX_EN  out  1  one-cycle start pulse to the TX core.
- TX_STATUS  in  1  TX core idle (1) / busy (0).
- RX_DATA  in  8  received byte; stable while RX_STATUS=1.
- RX_STATUS  in  1  RX byte-valid level from the RX core; asynchronous to clk.
- IRQ  out  1  level interrupt.

## Operation
- Register map (word addresses):
  - 0x4000_0018 TXDATA. Write pushes WriteData[7:0] into the TX FIFO. Read returns the last byte loaded to UART_TXD.
  - 0x4000_001C RXDATA. Read returns the RX FIFO head in [7:0] and pops it. If the FIFO is empty, the read returns 0 and does not pop. Writes are ignored.
  - 0x4000_0020 CON, R/W bits [1:0]:
    - bit0: RX-nonempty IRQ enable.
    - bit1: TX-drained IRQ enable.
  - 0x4000_0024 STATUS:
    - [0] rx_nonempty, [1] tx_full, [2] rx_ovf (sticky), [3] tx_ovf (sticky).
    - [7:4] tx_count, [11:8] rx_count.
    - Writing 1 to bit 2 or bit 3 clears that sticky bit; all other bits are read-only.
- TX FIFO:
  - A push when full (count==DEPTH at cycle start) is dropped and sets tx_ovf, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- TX FSM:
  - IDLE: if tx_count>0 and TX_STATUS=1, load the head into UART_TXD, assert TX_EN for one cycle, pop, and go to WAIT_BUSY.
  - WAIT_BUSY: stay until TX_STATUS=0, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: stay until TX_STATUS=1, then go to IDLE.
  - TX_EN is never asserted outside the IDLE→WAIT_BUSY transition.
- RX path:
  - RX_STATUS passes through two synchronizer flops, s1 then s2, followed by a history flop s3.
  - The rising edge (s2 & ~s3) pushes RX_DATA.
  - If the RX FIFO is full, the byte is dropped and rx_ovf is set.
  - A push and an RXDATA pop in the same cycle are both honoured. When full, the push still drops.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are 4 bits, range 0..DEPTH.
- IRQ = (CON[0] & rx_nonempty) | (CON[1] & tx_count==0 & FSM==IDLE).

## Timing
- Reset values:
  - UART_TXD=0, TX_EN=0, IRQ=0.
  - FSM=IDLE; CON=0.
  - Both FIFOs empty; sticky bits 0.
  - s1, s2 and s3 = 0.
- Reset asserted mid-transfer:
  - The FSM returns to IDLE and queued bytes are discarded.
  - TX_EN is low in the cycle after the reset edge.
- TX latency: a TXDATA store at edge N, with the FSM in IDLE and TX_STATUS=1, gives TX_EN=1 during cycle N+1→N+2. UART_TXD is valid in the same cycle.
- RX latency: when RX_STATUS is first sampled high at edge k, the byte is pushed at edge k+2. rx_count and STATUS reflect it from edge k+2.
- RX_STATUS must stay high ≥2 cycles and stay low ≥2 cycles between bytes.
- ReadData is combinational from the current state. A pop takes effect at the edge ending the read cycle.
- IRQ is a registered-state function and updates one cycle after the state change.

## Configuration
- UART_CTRL_IRQ_EN:
  - Defined: CON bits [1:0] and IRQ behave as specified.
  - Undefined: IRQ is tied to 0, CON reads 0, and writes to CON are ignored. All other behaviour is unchanged.

## Test plan
- Reset, then store 0x41 to TXDATA with TX_STATUS=1 -> TX_EN is a single-cycle pulse one cycle later with UART_TXD=0x41; the FSM waits for the TX_STATUS 1→0→1 sequence before sending the next byte.
- Store 9 bytes 0x00..0x08 back-to-back while TX_STATUS=0 (DEPTH=8) -> tx_count=8, the 9th byte is dropped, STATUS[3]=1; writing 0x8 to STATUS clears it.
- Pulse RX_STATUS 3 times with RX_DATA=0x10,0x20,0x30, then read RXDATA 4 times -> reads return 0x10, 0x20, 0x30, 0; rx_count goes 3→0.
- Fill the RX FIFO with 8 bytes, then in one cycle an RX push edge coincides with an RXDATA read -> the read returns the old head, the push is dropped, rx_ovf=1, rx_count=7.
- With UART_CTRL_IRQ_EN defined, CON=0x1 and one RX byte -> IRQ=1 until RXDATA is read; with CON=0x2 after the TX FIFO drains and the FSM returns to IDLE -> IRQ=1.
- Assert reset during WAIT_DONE with 3 bytes queued -> tx_count=0, FSM=IDLE, no further TX_EN pulses.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl
//
// Memory-mapped UART controller between the CPU data-memory bus and the
// UART TX/RX cores. CPU stores are queued in a TX FIFO and handed to the
// TX core one byte at a time using the TX_EN / TX_STATUS handshake.
// Received bytes are captured into an RX FIFO on each rising edge of the
// RX_STATUS strobe. Control, status and a level interrupt live in the
// 0x4000_0018 .. 0x4000_0024 peripheral window.
//
// Register map:
//   0x4000_0018 TXDATA  W: push byte, R: last byte loaded to UART_TXD
//   0x4000_001C RXDATA  R: pop RX FIFO head (0 when empty)
//   0x4000_0020 CON     R/W [1:0] interrupt enables
//   0x4000_0024 STATUS  R: {rx_count, tx_count, tx_ovf, rx_ovf, tx_full,
//                          rx_nonempty}; W1C on bits 2 and 3
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   Addr, WriteData       bus address and store data
//   MemRd, MemWr          load / store strobes
//   ReadData              combinational load data
//   UART_TXD, TX_EN       byte and one-cycle start pulse to the TX core
//   TX_STATUS             TX core idle (1) / busy (0)
//   RX_DATA, RX_STATUS    received byte and its valid level (asynchronous)
//   IRQ                   level interrupt
//
// Build option:
//   UART_CTRL_IRQ_EN  when defined, CON and IRQ are implemented; otherwise
//                     CON reads 0, writes to it are ignored and IRQ is 0.

module uart_fifo_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] ReadData,
    output logic [7:0]  UART_TXD,
    output logic        TX_EN,
    input  logic        TX_STATUS,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_STATUS,
    output logic        IRQ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    localparam logic [31:0] ADDR_TXDATA = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXDATA = 32'h4000_001C;
    localparam logic [31:0] ADDR_STATUS = 32'h4000_0024;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    tx_state_t tx_state;

    logic wr_txdata;
    logic rd_rxdata;
    logic wr_status;

    assign wr_txdata = MemWr && (Addr == ADDR_TXDATA);
    assign rd_rxdata = MemRd && (Addr == ADDR_RXDATA);
    assign wr_status = MemWr && (Addr == ADDR_STATUS);

    // Only the byte lane and the two W1C bits (plus CON bits when enabled)
    // of WriteData carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^{WriteData[31:4], WriteData[1:0]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wr_ptr;
    logic [PW-1:0] tx_rd_ptr;
    logic [3:0]    tx_count;
    logic          tx_full;
    logic          tx_push;
    logic          tx_drop;
    logic          tx_pop;
    logic          tx_ovf;

    assign tx_full = (tx_count == FULL_CNT);
    // Fullness is judged at cycle start, so a same-cycle pop does not
    // rescue a push into a full FIFO.
    assign tx_push = wr_txdata && !tx_full;
    assign tx_drop = wr_txdata && tx_full;
    assign tx_pop  = (tx_state == IDLE) && (tx_count != 4'd0) && TX_STATUS;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= 4'd0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 4'd1;
                2'b01:   tx_count <= tx_count - 4'd1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= WriteData[7:0];
    end

    // ------------------------------------------------------------------
    // TX handshake FSM: launch one byte, then wait for the core to go busy
    // and back to idle before launching the next.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            TX_EN    <= 1'b0;
            UART_TXD <= 8'd0;
        end else begin
            TX_EN <= 1'b0;
            case (tx_state)
                IDLE: begin
                    if (tx_pop) begin
                        UART_TXD <= tx_mem[tx_rd_ptr];
                        TX_EN    <= 1'b1;
                        tx_state <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!TX_STATUS) tx_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (TX_STATUS) tx_state <= IDLE;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX strobe synchronizer and edge detect
    // ------------------------------------------------------------------
    logic rx_s1;
    logic rx_s2;
    logic rx_s3;
    logic rx_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b0;
            rx_s2 <= 1'b0;
            rx_s3 <= 1'b0;
        end else begin
            rx_s1 <= RX_STATUS;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_edge = rx_s2 & ~rx_s3;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wr_ptr;
    logic [PW-1:0] rx_rd_ptr;
    logic [3:0]    rx_count;
    logic          rx_full;
    logic          rx_nonempty;
    logic          rx_push;
    logic          rx_drop;
    logic          rx_pop;
    logic          rx_ovf;

    assign rx_full     = (rx_count == FULL_CNT);
    assign rx_nonempty = (rx_count != 4'd0);
    assign rx_push     = rx_edge && !rx_full;
    assign rx_drop     = rx_edge && rx_full;
    assign rx_pop      = rd_rxdata && rx_nonempty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= 4'd0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 4'd1;
                2'b01:   rx_count <= rx_count - 4'd1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= RX_DATA;
    end

    // ------------------------------------------------------------------
    // Sticky overflow flags; a new overflow wins over a same-cycle clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_drop)                        tx_ovf <= 1'b1;
            else if (wr_status && WriteData[3]) tx_ovf <= 1'b0;
            if (rx_drop)                        rx_ovf <= 1'b1;
            else if (wr_status && WriteData[2]) rx_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control register and interrupt
    // ------------------------------------------------------------------
`ifdef UART_CTRL_IRQ_EN
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    logic [1:0] con;

    // IRQ is registered from the current state, so it follows a state
    // change by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            con <= 2'b00;
            IRQ <= 1'b0;
        end else begin
            if (MemWr && (Addr == ADDR_CON)) con <= WriteData[1:0];
            IRQ <= (con[0] & rx_nonempty) |
                   (con[1] & (tx_count == 4'd0) & (tx_state == IDLE));
        end
    end
`else
    assign IRQ = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    always_comb begin
        ReadData = 32'd0;
        if (MemRd) begin
            case (Addr)
                ADDR_TXDATA: ReadData = {24'd0, UART_TXD};
                ADDR_RXDATA: if (rx_nonempty) ReadData = {24'd0, rx_mem[rx_rd_ptr]};
`ifdef UART_CTRL_IRQ_EN
                ADDR_CON:    ReadData = {30'd0, con};
`endif
                ADDR_STATUS: ReadData = {20'd0, rx_count, tx_count, tx_ovf,
                                         rx_ovf, tx_full, rx_nonempty};
                default:     ReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl
//
// Directed testbench for uart_fifo_ctrl (DEPTH=8). Each scenario task drives
// bus and UART-core stimulus at the falling clock edge and compares DUT
// outputs against hand-computed values between rising edges.

module tb_uart_fifo_ctrl;

    localparam logic [31:0] A_TXDATA = 32'h4000_0018;
    localparam logic [31:0] A_RXDATA = 32'h4000_001C;
    localparam logic [31:0] A_CON    = 32'h4000_0020;
    localparam logic [31:0] A_STATUS = 32'h4000_0024;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] ReadData;
    logic [7:0]  UART_TXD;
    logic        TX_EN;
    logic        TX_STATUS;
    logic [7:0]  RX_DATA;
    logic        RX_STATUS;
    logic        IRQ;

    int tests_run;
    int tests_failed;

    uart_fifo_ctrl #(.DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .ReadData  (ReadData),
        .UART_TXD  (UART_TXD),
        .TX_EN     (TX_EN),
        .TX_STATUS (TX_STATUS),
        .RX_DATA   (RX_DATA),
        .RX_STATUS (RX_STATUS),
        .IRQ       (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One store cycle; returns at the falling edge after the store edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        WriteData = d;
        MemWr = 1'b1;
        @(negedge clk);
        MemWr = 1'b0;
    endtask

    // One load cycle; ReadData is captured before the edge that pops.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        Addr = a;
        MemRd = 1'b1;
        #1 d = ReadData;
        @(negedge clk);
        MemRd = 1'b0;
    endtask

    // Wait a bounded number of cycles for a TX_EN pulse.
    task automatic wait_tx_en(output logic seen, output logic [7:0] data);
        seen = 1'b0;
        data = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (TX_EN) begin
                seen = 1'b1;
                data = UART_TXD;
                break;
            end
        end
    endtask

    // Emulate the TX core going busy then idle again.
    task automatic tx_handshake();
        TX_STATUS = 1'b0;
        repeat (2) @(negedge clk);
        TX_STATUS = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One received byte: strobe high three cycles, low three cycles.
    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        RX_DATA = b;
        RX_STATUS = 1'b1;
        repeat (3) @(negedge clk);
        RX_STATUS = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (TX_EN !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_tx_en: got %b expected 0", TX_EN);
        end
        tests_run++;
        if (UART_TXD !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_uart_txd: got %h expected 00", UART_TXD);
        end
        tests_run++;
        if (IRQ !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_irq: got %b expected 0", IRQ);
        end
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %h expected 00000000", d);
        end
        bus_read(A_CON, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_con: got %h expected 00000000", d);
        end
        bus_read(A_RXDATA, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rxdata_empty: got %h expected 00000000", d);
        end
    endtask

    task automatic test_tx_single();
        logic       seen;
        logic [7:0] b;
        logic [31:0] d;
        int pulses;
        TX_STATUS = 1'b1;
        bus_write(A_TXDATA, 32'h41);
        tests_run++;
        if (TX_EN !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tx_en_early: got %b expected 0", TX_EN);
        end
        @(negedge clk);
        tests_run++;
        if (TX_EN !== 1'b1 || UART_TXD !== 8'h41) begin
            tests_failed++;
            $display("[TB] FAIL tx_first_byte: got en=%b data=%h expected en=1 data=41",
                     TX_EN, UART_TXD);
        end
        @(negedge clk);
        tests_run++;
        if (TX_EN !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tx_en_single_cycle: got %b expected 0", TX_EN);
        end
        // Second byte must wait for TX_STATUS 1->0->1.
        bus_write(A_TXDATA, 32'h42);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (TX_EN) pulses++;
        end
        TX_STATUS = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (TX_EN) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("[TB] FAIL tx_waits_handshake: got %0d pulses expected 0", pulses);
        end
        TX_STATUS = 1'b1;
        wait_tx_en(seen, b);
        tests_run++;
        if (seen !== 1'b1 || b !== 8'h42) begin
            tests_failed++;
            $display("[TB] FAIL tx_second_byte: got seen=%b data=%h expected seen=1 data=42",
                     seen, b);
        end
        bus_read(A_TXDATA, d);
        tests_run++;
        if (d !== 32'h42) begin
            tests_failed++;
            $display("[TB] FAIL txdata_readback: got %h expected 00000042", d);
        end
        tx_handshake();
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic        seen;
        logic [7:0]  b;
        @(negedge clk);
        TX_STATUS = 1'b0;
        MemWr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            Addr = A_TXDATA;
            WriteData = 32'(i);
            @(negedge clk);
        end
        MemWr = 1'b0;
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_008A) begin
            tests_failed++;
            $display("[TB] FAIL tx_overflow_status: got %h expected 0000008a", d);
        end
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0082) begin
            tests_failed++;
            $display("[TB] FAIL tx_ovf_clear: got %h expected 00000082", d);
        end
        // Drain: bytes 0..7 in order, the dropped 0x08 never appears.
        for (int i = 0; i < 8; i++) begin
            TX_STATUS = 1'b1;
            wait_tx_en(seen, b);
            tests_run++;
            if (seen !== 1'b1 || b !== 8'(i)) begin
                tests_failed++;
                $display("[TB] FAIL tx_drain_byte%0d: got seen=%b data=%h expected seen=1 data=%h",
                         i, seen, b, 8'(i));
            end
            TX_STATUS = 1'b0;
            repeat (2) @(negedge clk);
        end
        TX_STATUS = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL tx_drained_status: got %h expected 00000000", d);
        end
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        logic [31:0] exp_bytes [4];
        exp_bytes[0] = 32'h10;
        exp_bytes[1] = 32'h20;
        exp_bytes[2] = 32'h30;
        exp_bytes[3] = 32'h00;
        rx_pulse(8'h10);
        rx_pulse(8'h20);
        rx_pulse(8'h30);
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0301) begin
            tests_failed++;
            $display("[TB] FAIL rx_count3_status: got %h expected 00000301", d);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_RXDATA, d);
            tests_run++;
            if (d !== exp_bytes[i]) begin
                tests_failed++;
                $display("[TB] FAIL rx_read%0d: got %h expected %h", i, d, exp_bytes[i]);
            end
        end
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL rx_empty_status: got %h expected 00000000", d);
        end
    endtask

    task automatic test_rx_full_collision();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) rx_pulse(8'(8'h80 + i));
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0801) begin
            tests_failed++;
            $display("[TB] FAIL rx_full_status: got %h expected 00000801", d);
        end
        // Rising strobe sampled at edge k pushes at edge k+2; the read
        // cycle is arranged to end at that same edge.
        @(negedge clk);
        RX_DATA = 8'h99;
        RX_STATUS = 1'b1;
        repeat (2) @(negedge clk);
        Addr = A_RXDATA;
        MemRd = 1'b1;
        #1 d = ReadData;
        @(negedge clk);
        MemRd = 1'b0;
        RX_STATUS = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (d !== 32'h80) begin
            tests_failed++;
            $display("[TB] FAIL rx_collision_read: got %h expected 00000080", d);
        end
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0705) begin
            tests_failed++;
            $display("[TB] FAIL rx_collision_status: got %h expected 00000705", d);
        end
        bus_write(A_STATUS, 32'h4);
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0701) begin
            tests_failed++;
            $display("[TB] FAIL rx_ovf_clear: got %h expected 00000701", d);
        end
        for (int i = 1; i < 8; i++) begin
            bus_read(A_RXDATA, d);
            tests_run++;
            if (d !== 32'(8'h80 + i)) begin
                tests_failed++;
                $display("[TB] FAIL rx_drain%0d: got %h expected %h", i, d, 32'(8'h80 + i));
            end
        end
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL rx_drop_not_stored: got %h expected 00000000", d);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
`ifdef UART_CTRL_IRQ_EN
        bus_write(A_CON, 32'h1);
        bus_read(A_CON, d);
        tests_run++;
        if (d !== 32'h1) begin
            tests_failed++;
            $display("[TB] FAIL con_readback: got %h expected 00000001", d);
        end
        rx_pulse(8'h55);
        tests_run++;
        if (IRQ !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL irq_rx_set: got %b expected 1", IRQ);
        end
        bus_read(A_RXDATA, d);
        @(negedge clk);
        tests_run++;
        if (IRQ !== 1'b0 || d !== 32'h55) begin
            tests_failed++;
            $display("[TB] FAIL irq_rx_clear: got irq=%b data=%h expected irq=0 data=00000055",
                     IRQ, d);
        end
        bus_write(A_CON, 32'h2);
        @(negedge clk);
        tests_run++;
        if (IRQ !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL irq_tx_drained: got %b expected 1", IRQ);
        end
        bus_write(A_CON, 32'h0);
        @(negedge clk);
        tests_run++;
        if (IRQ !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_disabled: got %b expected 0", IRQ);
        end
`else
        bus_write(A_CON, 32'h3);
        bus_read(A_CON, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL con_reads_zero: got %h expected 00000000", d);
        end
        rx_pulse(8'h55);
        tests_run++;
        if (IRQ !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_tied_low: got %b expected 0", IRQ);
        end
        bus_read(A_RXDATA, d);
        tests_run++;
        if (d !== 32'h55) begin
            tests_failed++;
            $display("[TB] FAIL irq_off_rx_read: got %h expected 00000055", d);
        end
`endif
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] d;
        logic        seen;
        logic [7:0]  b;
        int pulses;
        // First byte launches immediately, three remain queued.
        TX_STATUS = 1'b1;
        @(negedge clk);
        MemWr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Addr = A_TXDATA;
            WriteData = 32'(8'hA0 + i);
            @(negedge clk);
        end
        MemWr = 1'b0;
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0000_0030) begin
            tests_failed++;
            $display("[TB] FAIL mid_queue_status: got %h expected 00000030", d);
        end
        TX_STATUS = 1'b0;
        repeat (2) @(negedge clk);
        // Core returns to idle exactly as reset hits WAIT_DONE.
        reset = 1'b1;
        TX_STATUS = 1'b1;
        @(negedge clk);
        tests_run++;
        if (TX_EN !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_tx_en_low: got %b expected 0", TX_EN);
        end
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (TX_EN) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_pulses: got %0d pulses expected 0", pulses);
        end
        bus_read(A_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_queue_flushed: got %h expected 00000000", d);
        end
        bus_write(A_TXDATA, 32'h5A);
        wait_tx_en(seen, b);
        tests_run++;
        if (seen !== 1'b1 || b !== 8'h5A) begin
            tests_failed++;
            $display("[TB] FAIL reset_fsm_idle: got seen=%b data=%h expected seen=1 data=5a",
                     seen, b);
        end
        tx_handshake();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        Addr = 32'h0;
        WriteData = 32'h0;
        MemRd = 1'b0;
        MemWr = 1'b0;
        TX_STATUS = 1'b1;
        RX_DATA = 8'h00;
        RX_STATUS = 1'b0;

        test_reset();
        test_tx_single();
        test_tx_overflow();
        test_rx_basic();
        test_rx_full_collision();
        test_irq();
        test_reset_mid_transfer();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
